pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_stage_elastic.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer, and a saturating stall-cycle counter.
module pipe_stage_elastic #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic              mainValid;
  logic [CNT_W-1:0]  stallCnt;
  logic              inFire;
  logic              outFire;

  assign inFire  = in_valid & in_ready;
  assign outFire = mainValid & out_ready;

  generate
    if (SKID != 0) begin : gSkid
      typedef enum logic [1:0] {EMPTY, ONE, TWO} stateType;

      stateType          state;
      logic [DATA_W-1:0] skidData;
      logic [CTRL_W-1:0] skidCtrl;
      logic              readyReg;

      // NOTE: every register here uses <= so all next-state values are
      // computed from the same pre-edge snapshot, independent of statement order.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          state     <= EMPTY;
          mainValid <= 1'b0;
          mainData  <= '0;
          mainCtrl  <= '0;
          skidData  <= '0;
          skidCtrl  <= '0;
          readyReg  <= 1'b1;
        end else if (flush) begin
          // Payload is left as-is; only valid/ctrl must read as a bubble.
          state     <= EMPTY;
          mainValid <= 1'b0;
          mainCtrl  <= '0;
          skidCtrl  <= '0;
          readyReg  <= 1'b1;
        end else begin
          unique case (state)
            EMPTY: begin
              if (inFire) begin
                mainData  <= in_data;
                mainCtrl  <= in_ctrl;
                mainValid <= 1'b1;
                state     <= ONE;
              end
            end
            ONE: begin
              if (inFire && outFire) begin
                mainData <= in_data;
                mainCtrl <= in_ctrl;
              end else if (outFire) begin
                mainValid <= 1'b0;
                mainCtrl  <= '0;
                state     <= EMPTY;
              end else if (inFire) begin
                skidData <= in_data;
                skidCtrl <= in_ctrl;
                readyReg <= 1'b0;
                state    <= TWO;
              end
            end
            TWO: begin
              if (outFire) begin
                mainData <= skidData;
                mainCtrl <= skidCtrl;
                skidCtrl <= '0;
                readyReg <= 1'b1;
                state    <= ONE;
              end
            end
            default: begin
              state     <= EMPTY;
              mainValid <= 1'b0;
              mainCtrl  <= '0;
              readyReg  <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready = resetn & readyReg;
    end else begin : gNoSkid
      always_ff @(posedge clk) begin
        if (!resetn) begin
          mainValid <= 1'b0;
          mainData  <= '0;
          mainCtrl  <= '0;
        end else if (flush) begin
          mainValid <= 1'b0;
          mainCtrl  <= '0;
        end else if (inFire) begin
          mainData  <= in_data;
          mainCtrl  <= in_ctrl;
          mainValid <= 1'b1;
        end else if (outFire) begin
          mainValid <= 1'b0;
          mainCtrl  <= '0;
        end
      end

      // Only combinational path through the stage: out_ready -> in_ready.
      assign in_ready = resetn & (~mainValid | out_ready);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stallCnt <= '0;
    end else if (mainValid && !out_ready && !flush && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign out_ctrl  = mainCtrl;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: skid streaming/back-pressure/flush,
// combinational-ready variant, and stall counter saturation.
module tb_pipe_stage_elastic;

  localparam int DW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // DUT A: skid buffer, 16-bit counter
  logic inValidA, inReadyA, flushA, outValidA, outReadyA;
  logic [DW-1:0] inDataA, outDataA;
  logic [CW-1:0] inCtrlA, outCtrlA;
  logic [15:0]   stallA;
  // DUT B: single entry, combinational ready
  logic inValidB, inReadyB, flushB, outValidB, outReadyB;
  logic [DW-1:0] inDataB, outDataB;
  logic [CW-1:0] inCtrlB, outCtrlB;
  logic [15:0]   stallB;
  // DUT C: skid buffer, 4-bit counter
  logic inValidC, inReadyC, flushC, outValidC, outReadyC;
  logic [DW-1:0] inDataC, outDataC;
  logic [CW-1:0] inCtrlC, outCtrlC;
  logic [3:0]    stallC;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dutA (
    .clk(clk), .resetn(resetn), .in_valid(inValidA), .in_ready(inReadyA),
    .in_data(inDataA), .in_ctrl(inCtrlA), .flush(flushA), .out_valid(outValidA),
    .out_ready(outReadyA), .out_data(outDataA), .out_ctrl(outCtrlA), .stall_cnt(stallA));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dutB (
    .clk(clk), .resetn(resetn), .in_valid(inValidB), .in_ready(inReadyB),
    .in_data(inDataB), .in_ctrl(inCtrlB), .flush(flushB), .out_valid(outValidB),
    .out_ready(outReadyB), .out_data(outDataB), .out_ctrl(outCtrlB), .stall_cnt(stallB));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dutC (
    .clk(clk), .resetn(resetn), .in_valid(inValidC), .in_ready(inReadyC),
    .in_data(inDataC), .in_ctrl(inCtrlC), .flush(flushC), .out_valid(outValidC),
    .out_ready(outReadyC), .out_data(outDataC), .out_ctrl(outCtrlC), .stall_cnt(stallC));

  // Scoreboards: {ctrl, data} pushed on accepted input, popped on output transfer.
  logic [CW+DW-1:0] sbA[$];
  logic [CW+DW-1:0] sbB[$];
  logic [CW+DW-1:0] sbC[$];

  always @(negedge clk) begin : monA
    logic [CW+DW-1:0] e;
    if (resetn) begin
      if (!outValidA) check("A_bubble_ctrl", 64'(outCtrlA), 64'(0));
      if (outValidA && outReadyA) begin
        if (sbA.size() == 0) check("A_extra_beat", 64'(outValidA), 64'(0));
        else begin
          e = sbA.pop_front();
          check("A_out", 64'({outCtrlA, outDataA}), 64'(e));
        end
      end
      if (flushA) sbA.delete();
      else if (inValidA && inReadyA) sbA.push_back({inCtrlA, inDataA});
    end
  end

  always @(negedge clk) begin : monB
    logic [CW+DW-1:0] e;
    if (resetn) begin
      if (!outValidB) check("B_bubble_ctrl", 64'(outCtrlB), 64'(0));
      if (outValidB && outReadyB) begin
        if (sbB.size() == 0) check("B_extra_beat", 64'(outValidB), 64'(0));
        else begin
          e = sbB.pop_front();
          check("B_out", 64'({outCtrlB, outDataB}), 64'(e));
        end
      end
      if (flushB) sbB.delete();
      else if (inValidB && inReadyB) sbB.push_back({inCtrlB, inDataB});
    end
  end

  always @(negedge clk) begin : monC
    logic [CW+DW-1:0] e;
    if (resetn) begin
      if (outValidC && outReadyC) begin
        if (sbC.size() == 0) check("C_extra_beat", 64'(outValidC), 64'(0));
        else begin
          e = sbC.pop_front();
          check("C_out", 64'({outCtrlC, outDataC}), 64'(e));
        end
      end
      if (flushC) sbC.delete();
      else if (inValidC && inReadyC) sbC.push_back({inCtrlC, inDataC});
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic r;
    resetn = 1'b0;
    inValidA = 1'b1; inDataA = 8'h55; inCtrlA = 4'hF; flushA = 1'b0; outReadyA = 1'b0;
    inValidB = 1'b1; inDataB = 8'h55; inCtrlB = 4'hF; flushB = 1'b0; outReadyB = 1'b0;
    inValidC = 1'b1; inDataC = 8'h55; inCtrlC = 4'hF; flushC = 1'b0; outReadyC = 1'b0;

    // Reset with in_valid held high
    repeat (3) step();
    check("rst_out_valid", 64'(outValidA), 64'(0));
    check("rst_out_ctrl", 64'(outCtrlA), 64'(0));
    check("rst_out_data", 64'(outDataA), 64'(0));
    check("rst_stall", 64'(stallA), 64'(0));
    check("rst_in_ready_A", 64'(inReadyA), 64'(0));
    check("rst_in_ready_B", 64'(inReadyB), 64'(0));
    resetn = 1'b1;
    inValidA = 1'b0; inValidB = 1'b0; inValidC = 1'b0;
    #1;
    check("post_rst_ready_A", 64'(inReadyA), 64'(1));
    check("post_rst_ready_B", 64'(inReadyB), 64'(1));

    // Streaming 1..8 through the skid stage
    outReadyA = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i > 1) begin
        check("stream_valid", 64'(outValidA), 64'(1));
        check("stream_data", 64'(outDataA), 64'(i - 1));
      end
      inValidA = 1'b1;
      inDataA  = DW'(i);
      inCtrlA  = CW'(i) ^ 4'hA;
      check("stream_ready", 64'(inReadyA), 64'(1));
    end
    step();
    inValidA = 1'b0;
    check("stream_last", 64'(outDataA), 64'(8));
    step();
    check("stream_drained", 64'(outValidA), 64'(0));

    // Back-pressure: A held, B in skid, C refused
    outReadyA = 1'b0;
    inValidA = 1'b1; inDataA = 8'h0A; inCtrlA = 4'h1;
    step();
    check("bp_ready_after_A", 64'(inReadyA), 64'(1));
    inDataA = 8'h0B; inCtrlA = 4'h2;
    step();
    check("bp_ready_after_B", 64'(inReadyA), 64'(0));
    check("bp_head_A", 64'(outDataA), 64'(8'h0A));
    inDataA = 8'h0C; inCtrlA = 4'h3;
    repeat (3) step();
    check("bp_hold_A", 64'(outDataA), 64'(8'h0A));
    check("bp_hold_ctrl", 64'(outCtrlA), 64'(4'h1));
    check("bp_still_blocked", 64'(inReadyA), 64'(0));
    check("bp_stall_cnt", 64'(stallA), 64'(4));
    outReadyA = 1'b1;
    step();
    check("bp_head_B", 64'(outDataA), 64'(8'h0B));
    check("bp_ready_reopen", 64'(inReadyA), 64'(1));
    step();
    check("bp_head_C", 64'(outDataA), 64'(8'h0C));
    inValidA = 1'b0;
    step();
    check("bp_empty", 64'(outValidA), 64'(0));
    check("bp_stall_final", 64'(stallA), 64'(4));

    // Flush while TWO with an incoming beat
    outReadyA = 1'b0;
    inValidA = 1'b1; inDataA = 8'h0D; inCtrlA = 4'h4;
    step();
    inDataA = 8'h0E; inCtrlA = 4'h5;
    step();
    check("fl_two_ready", 64'(inReadyA), 64'(0));
    inDataA = 8'h0F; inCtrlA = 4'h6;
    flushA = 1'b1;
    step();
    flushA = 1'b0; inValidA = 1'b0;
    check("fl_two_valid", 64'(outValidA), 64'(0));
    check("fl_two_ctrl", 64'(outCtrlA), 64'(0));
    check("fl_two_ready_after", 64'(inReadyA), 64'(1));
    check("fl_two_stall", 64'(stallA), 64'(5));

    // Flush while ONE: same-cycle accepted beat is discarded, payload retained
    inValidA = 1'b1; inDataA = 8'h10; inCtrlA = 4'h7;
    step();
    inDataA = 8'h11; inCtrlA = 4'h8;
    flushA = 1'b1;
    check("fl_one_ready", 64'(inReadyA), 64'(1));
    step();
    flushA = 1'b0; inValidA = 1'b0;
    check("fl_one_valid", 64'(outValidA), 64'(0));
    check("fl_one_data_kept", 64'(outDataA), 64'(8'h10));
    outReadyA = 1'b1;
    repeat (3) step();
    check("fl_no_ghost", 64'(outValidA), 64'(0));
    check("fl_stall_final", 64'(stallA), 64'(5));

    // SKID=0: in_ready follows out_ready in the same cycle
    inValidB = 1'b1; inDataB = 8'h01; inCtrlB = 4'h1 ^ 4'hA;
    step();
    check("b_loaded", 64'(outValidB), 64'(1));
    for (int k = 0; k < 8; k++) begin
      r = (k % 2) == 1;
      outReadyB = r;
      #1;
      check("b_comb_ready", 64'(inReadyB), 64'(r));
      step();
      if (r) begin
        inDataB = inDataB + 8'h01;
        inCtrlB = inDataB[3:0] ^ 4'hA;
      end
    end
    inValidB = 1'b0;
    outReadyB = 1'b1;
    repeat (3) step();
    check("b_drained", 64'(outValidB), 64'(0));

    // Saturation with a 4-bit counter
    inValidC = 1'b1; inDataC = 8'h77; inCtrlC = 4'h9;
    step();
    inValidC = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j == 10) check("sat_mid", 64'(stallC), 64'(10));
      if (j == 15) check("sat_reach", 64'(stallC), 64'(15));
    end
    check("sat_hold", 64'(stallC), 64'(15));
    outReadyC = 1'b1;
    repeat (2) step();
    check("sat_after_drain", 64'(stallC), 64'(15));
    check("c_drained", 64'(outValidC), 64'(0));

    check("sbA_empty", 64'(sbA.size()), 64'(0));
    check("sbB_empty", 64'(sbB.size()), 64'(0));
    check("sbC_empty", 64'(sbC.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
